// File: rtl/scan_chain_ctrl.sv
// Scan test sequencer: serially loads a pattern into an FF_scan chain, pulses one
// functional capture cycle, unloads the chain and compares it against an expected vector.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SD,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [CHAIN_LEN-1:0] mismatch
);
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t               stateReg;
    logic [CW-1:0]        bitCntReg;
    logic [CHAIN_LEN-1:0] sdShiftReg;
    logic [CHAIN_LEN-1:0] expectedReg;
    logic [CHAIN_LEN-1:0] capFull;

    // The last unload edge stores SO into bit 0, so the verdict uses that bit directly.
    assign capFull = {captured[CHAIN_LEN-1:1], SO};

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            bitCntReg   <= '0;
            sdShiftReg  <= '0;
            expectedReg <= '0;
            SE          <= 1'b0;
            SD          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            captured    <= '0;
            mismatch    <= '0;
        end else begin
            done <= 1'b0;
            case (stateReg)
                // DONE's closing edge may accept the next test so back-to-back runs keep a 2N+2 period.
                IDLE, DONE: begin
                    SE   <= 1'b0;
                    SD   <= 1'b0;
                    busy <= 1'b0;
                    stateReg <= IDLE;
                    if (start) begin
                        stateReg    <= SHIFT_IN;
                        bitCntReg   <= '0;
                        expectedReg <= expected;
                        sdShiftReg  <= pattern_in << 1;
                        SE          <= 1'b1;
                        SD          <= pattern_in[CHAIN_LEN-1];
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                    end
                end
                SHIFT_IN: begin
                    if (bitCntReg == LAST_CNT) begin
                        stateReg  <= CAPTURE;
                        bitCntReg <= '0;
                        SE        <= 1'b0;
                        SD        <= 1'b0;
                    end else begin
                        bitCntReg  <= bitCntReg + 1'b1;
                        SD         <= sdShiftReg[CHAIN_LEN-1];
                        sdShiftReg <= sdShiftReg << 1;
                    end
                end
                CAPTURE: begin
                    stateReg  <= SHIFT_OUT;
                    bitCntReg <= '0;
                    SE        <= 1'b1;
                    SD        <= 1'b0;
                end
                SHIFT_OUT: begin
                    captured[LAST_CNT - bitCntReg] <= SO;
                    if (bitCntReg == LAST_CNT) begin
                        stateReg  <= DONE;
                        bitCntReg <= '0;
                        SE        <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (capFull == expectedReg);
                        mismatch  <= capFull ^ expectedReg;
                    end else begin
                        bitCntReg <= bitCntReg + 1'b1;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    SE       <= 1'b0;
                    SD       <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: inverter-per-cell chain models, a queue-based scoreboard
// and a per-cycle protocol monitor derived from the acceptance edge.
module tb_scan_chain_ctrl;
    localparam int N    = 8;
    localparam int N2   = 2;
    localparam int LAT  = 2 * N + 2;
    localparam int LAT2 = 2 * N2 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic [7:0] patternIn = '0, expectedIn = '0;
    logic [1:0] pattern2 = '0, expected2 = '0;
    logic       se, sd, busy, done, pass;
    logic [7:0] captured, mismatch;
    logic       se2, sd2, busy2, done2, pass2;
    logic [1:0] captured2, mismatch2;
    logic [7:0] chain = '0;
    logic [1:0] chain2 = '0;
    bit         bypass = 1'b0;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_in(patternIn), .expected(expectedIn),
        .SO(chain[N-1]), .SE(se), .SD(sd), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch(mismatch)
    );

    scan_chain_ctrl #(.CHAIN_LEN(N2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .pattern_in(pattern2), .expected(expected2),
        .SO(chain2[N2-1]), .SE(se2), .SD(sd2), .busy(busy2), .done(done2), .pass(pass2),
        .captured(captured2), .mismatch(mismatch2)
    );

    // Chain of FF_scan cells with D = ~Q; bypass holds the chain in capture instead.
    always @(posedge clk) begin
        if (se) chain <= {chain[N-2:0], sd};
        else if (!bypass) chain <= ~chain;
        if (se2) chain2 <= {chain2[0], sd2};
        else chain2 <= ~chain2;
    end

    typedef struct {
        logic [7:0] cap;
        logic [7:0] mis;
        bit         pass;
        int         doneCyc;
    } item_t;

    item_t q8[$];
    item_t q2[$];
    int cyc = 0, total = 0, bad = 0;
    int acc8 = -1000, acc2 = -1000;
    logic [7:0] pat8 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // One clock edge; the bench decides acceptance from its own notion of when the block is free.
    task automatic step();
        item_t it;
        logic [7:0] c;
        @(posedge clk);
        cyc++;
        if (reset) begin
            acc8 = -1000;
            acc2 = -1000;
            q8.delete();
            q2.delete();
        end else begin
            if (start && (cyc - acc8 >= LAT)) begin
                acc8 = cyc;
                pat8 = patternIn;
                c = bypass ? patternIn : ~patternIn;
                it.cap = c; it.mis = c ^ expectedIn; it.pass = (c == expectedIn);
                it.doneCyc = cyc + 2 * N + 1;
                q8.push_back(it);
            end
            if (start2 && (cyc - acc2 >= LAT2)) begin
                acc2 = cyc;
                c = {6'b0, ~pattern2};
                it.cap = c; it.mis = c ^ {6'b0, expected2}; it.pass = (c[1:0] == expected2);
                it.doneCyc = cyc + 2 * N2 + 1;
                q2.push_back(it);
            end
        end
        #2;
    endtask

    always @(negedge clk) begin
        int d;
        item_t it;
        if (cyc >= 1) begin
            d = cyc - acc8;
            check("se", {31'b0, se}, {31'b0, ((d >= 0 && d <= N - 1) || (d >= N + 1 && d <= 2 * N))});
            check("busy", {31'b0, busy}, {31'b0, (d >= 0 && d <= 2 * N + 1)});
            if (d >= 0 && d <= N - 1) check("sd", {31'b0, sd}, {31'b0, pat8[N-1-d]});
            while (q8.size() > 0 && q8[0].doneCyc < cyc) begin
                check("done_missing", 32'd0, 32'd1);
                void'(q8.pop_front());
            end
            if (done) begin
                if (q8.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    it = q8.pop_front();
                    check("done_cycle", cyc, it.doneCyc);
                    check("captured", {24'b0, captured}, {24'b0, it.cap});
                    check("mismatch", {24'b0, mismatch}, {24'b0, it.mis});
                    check("pass", {31'b0, pass}, {31'b0, it.pass});
                    $display("test N=8 done at cycle %0d captured=%h pass=%0b", cyc, captured, pass);
                end
            end
            while (q2.size() > 0 && q2[0].doneCyc < cyc) begin
                check("done2_missing", 32'd0, 32'd1);
                void'(q2.pop_front());
            end
            if (done2) begin
                if (q2.size() == 0) check("done2_unexpected", 32'd1, 32'd0);
                else begin
                    it = q2.pop_front();
                    check("done2_cycle", cyc, it.doneCyc);
                    check("captured2", {30'b0, captured2}, {24'b0, it.cap});
                    check("mismatch2", {30'b0, mismatch2}, {24'b0, it.mis});
                    check("pass2", {31'b0, pass2}, {31'b0, it.pass});
                    $display("test N=2 done at cycle %0d captured=%b pass=%0b", cyc, captured2, pass2);
                end
            end
        end
    end

    task automatic runTest(input logic [7:0] pat, input logic [7:0] exp, input bit bp, input int blip);
        bypass = bp;
        patternIn = pat;
        expectedIn = exp;
        start = 1'b1;
        step();
        start = 1'b0;
        patternIn = 8'($urandom);
        expectedIn = 8'($urandom);
        for (int i = 1; i < LAT; i++) begin
            if (i == blip) start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] p;
        repeat (3) step();
        reset = 1'b0;
        check("rst_se", {31'b0, se}, 32'd0);
        check("rst_sd", {31'b0, sd}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_captured", {24'b0, captured}, 32'd0);
        check("rst_mismatch", {24'b0, mismatch}, 32'd0);
        step();

        runTest(8'hA5, 8'h5A, 1'b0, 0);
        runTest(8'hA5, 8'h5B, 1'b0, 5);
        runTest(8'h80, 8'h80, 1'b1, 0);
        bypass = 1'b0;

        // start held high: accepts only once the previous test has finished
        patternIn = 8'h3C;
        expectedIn = 8'hC3;
        start = 1'b1;
        repeat (40) step();
        start = 1'b0;
        repeat (LAT) step();

        // reset during SHIFT_OUT cycle 3
        patternIn = 8'h96;
        expectedIn = 8'h69;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_se", {31'b0, se}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_captured", {24'b0, captured}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        repeat (20) step();
        runTest(8'hFF, 8'h00, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            p = 8'($urandom);
            runTest(p, ($urandom_range(1) == 1) ? ~p : 8'($urandom), 1'b0,
                    ($urandom_range(1) == 1) ? int'($urandom_range(LAT - 1, 1)) : 0);
            repeat ($urandom_range(3)) step();
        end

        pattern2 = 2'b10;
        expected2 = 2'b01;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        repeat (LAT2 + 2) step();
        for (int t = 0; t < 4; t++) begin
            pattern2 = 2'($urandom);
            expected2 = 2'($urandom);
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            pattern2 = 2'($urandom);
            repeat (LAT2) step();
        end

        repeat (4) step();
        check("pending8", q8.size(), 32'd0);
        check("pending2", q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
